// File: rtl/led_rate_scheduler_if.sv
// Board-side bundle for the LED rate scheduler.
// Raw enable/switch inputs in, LED drive and status out.
interface led_rate_scheduler_if;
  logic       enable;
  logic [3:0] sw;
  logic [3:0] led;
  logic [1:0] state;
  logic [7:0] rate_sel;

  modport master (
    output enable,
    output sw,
    input  led,
    input  state,
    input  rate_sel
  );

  modport slave (
    input  enable,
    input  sw,
    output led,
    output state,
    output rate_sel
  );
endinterface

// File: rtl/led_rate_scheduler.sv
// Four-channel LED blinker with per-channel selectable rate.
// Tick prescaler, switch debounce, OFF/LAMP/RUN sequencer.
module led_rate_scheduler #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TICK_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int LAMP_TICKS     = 500
) (
  input logic                clock,
  input logic                reset_n,
  led_rate_scheduler_if.slave bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam int HP0 = TICK_HZ / 200;
  localparam int HP1 = TICK_HZ / 100;
  localparam int HP2 = TICK_HZ / 20;
  localparam int HP3 = TICK_HZ / 2;
  localparam int CW  = (HP3 > 1) ? $clog2(HP3) : 1;

  localparam int DW0 = $clog2(DEBOUNCE_TICKS + 1);
  localparam int DW  = (DW0 > 0) ? DW0 : 1;
  localparam int LW0 = $clog2(LAMP_TICKS + 1);
  localparam int LW  = (LW0 > 0) ? LW0 : 1;

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_LAMP = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [LW-1:0] LAMP_LAST = LW'(LAMP_TICKS - 1);

  // last counter value of a half period for a rate index
  function automatic logic [CW-1:0] hp_last(input logic [1:0] r);
    logic [CW-1:0] v;
    v = CW'(HP3 - 1);
    case (r)
      2'd0: v = CW'(HP0 - 1);
      2'd1: v = CW'(HP1 - 1);
      2'd2: v = CW'(HP2 - 1);
      2'd3: v = CW'(HP3 - 1);
      default: v = CW'(HP3 - 1);
    endcase
    return v;
  endfunction

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  logic          en_s1_q, en_s2_q;
  logic [3:0]    sw_s1_q, sw_s2_q;

  logic [3:0][DW-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]         deb_q, deb_d;
  logic [3:0]         deb_prev_q;
  logic [3:0]         step;

  logic [7:0]    rate_q, rate_d;

  logic [1:0]    st_q, st_d;
  logic [LW-1:0] lamp_q, lamp_d;

  logic [3:0][CW-1:0] ch_q, ch_d;
  logic [3:0]         led_q, led_d;

  assign tick = (pre_q == PRE_LAST);

  // free-running tick prescaler
  always_comb begin
    pre_d = pre_q + PW'(1);
    if (tick) begin
      pre_d = '0;
    end
  end

  // prescaler register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // two-stage synchronizers for the asynchronous board inputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en_s1_q <= 1'b0;
      en_s2_q <= 1'b0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      en_s1_q <= bus.enable;
      en_s2_q <= en_s1_q;
      sw_s1_q <= bus.sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  // debounce: a new level must persist for DEBOUNCE_TICKS ticks
  always_comb begin
    db_cnt_d = db_cnt_q;
    deb_d    = deb_q;
    for (int i = 0; i < 4; i++) begin
      if (sw_s2_q[i] == deb_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (tick) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i]    = sw_s2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // debounce state and previous value for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt_q   <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
    end
  end

  assign step = deb_q & ~deb_prev_q;

  // each accepted press advances that channel's rate, wrapping
  always_comb begin
    rate_d = rate_q;
    for (int i = 0; i < 4; i++) begin
      if (step[i]) begin
        rate_d[2*i +: 2] = rate_q[2*i +: 2] + 2'd1;
      end
    end
  end

  // rate selection register, all channels start at 1 Hz
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rate_q <= 8'hFF;
    end else begin
      rate_q <= rate_d;
    end
  end

  // OFF -> LAMP -> RUN sequencer driven by the synced enable
  always_comb begin
    st_d   = st_q;
    lamp_d = lamp_q;
    unique case (st_q)
      S_OFF: begin
        lamp_d = '0;
        if (en_s2_q) begin
          st_d = (LAMP_TICKS == 0) ? S_RUN : S_LAMP;
        end
      end
      S_LAMP: begin
        if (!en_s2_q) begin
          st_d   = S_OFF;
          lamp_d = '0;
        end else if (tick) begin
          if (lamp_q == LAMP_LAST) begin
            st_d   = S_RUN;
            lamp_d = '0;
          end else begin
            lamp_d = lamp_q + LW'(1);
          end
        end
      end
      S_RUN: begin
        lamp_d = '0;
        if (!en_s2_q) begin
          st_d = S_OFF;
        end
      end
      default: begin
        st_d   = S_OFF;
        lamp_d = '0;
      end
    endcase
  end

  // sequencer state and lamp-test counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= S_OFF;
      lamp_q <= '0;
    end else begin
      st_q   <= st_d;
      lamp_q <= lamp_d;
    end
  end

  // per-channel half-period counters; a rate change restarts
  // the channel and takes priority over a same-cycle toggle
  always_comb begin
    ch_d  = ch_q;
    led_d = led_q;
    for (int i = 0; i < 4; i++) begin
      if (st_q != S_RUN || st_d != S_RUN) begin
        ch_d[i]  = '0;
        led_d[i] = (st_d == S_LAMP);
      end else if (step[i]) begin
        ch_d[i]  = '0;
        led_d[i] = 1'b0;
      end else if (tick) begin
        if (ch_q[i] == hp_last(rate_q[2*i +: 2])) begin
          ch_d[i]  = '0;
          led_d[i] = ~led_q[i];
        end else begin
          ch_d[i] = ch_q[i] + CW'(1);
        end
      end
    end
  end

  // channel counters and registered LED drive
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ch_q  <= '0;
      led_q <= '0;
    end else begin
      ch_q  <= ch_d;
      led_q <= led_d;
    end
  end

  assign bus.led      = led_q;
  assign bus.state    = st_q;
  assign bus.rate_sel = rate_q;

endmodule
